// File: rtl/aes_ks_pkg.sv
// Shared definitions for the AES key-schedule engine: key-size derivations,
// GF(2^8) doubling and the controller state encoding.
package aes_ks_pkg;

    typedef enum logic {IDLE, EXPAND} ks_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic int ks_nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int ks_nr(input int key_bits);
        return ks_nk(key_bits) + 6;
    endfunction

    function automatic int ks_nw(input int key_bits);
        return 4 * (ks_nr(key_bits) + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four parallel AES S-box lookups on one 32-bit word; purely combinational so
// the cipher round logic can share it.
module aes_subword (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                       SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into a
// flat register store, round keys read through a registered port. AES_KS_ZEROIZE_EN adds key_clr.
module aes_key_schedule
    import aes_ks_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                done,
    output logic                key_valid,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key
`ifdef AES_KS_ZEROIZE_EN
    ,
    input  logic                key_clr
`endif
);

    localparam int NK = ks_nk(KEY_BITS);
    localparam int NR = ks_nr(KEY_BITS);
    localparam int NW = ks_nw(KEY_BITS);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    logic [31:0] w [NW];
    ks_state_e   state, state_nx;
    logic [5:0]  idx;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic        accept, step, last;
    logic [31:0] temp_prev, sub_in, sub_out, temp, w_new;
    logic [5:0]  rd_base;

    assign busy   = (state == EXPAND);
    assign accept = (state == IDLE) && start;
    assign step   = (state == EXPAND);
    assign last   = (idx == 6'(NW - 1));

    // phase tracks i mod Nk so the RotWord/Rcon and AES-256 SubWord slots need no divider
    assign temp_prev = w[idx - 6'd1];
    assign sub_in    = (phase == 3'd0) ? {temp_prev[23:0], temp_prev[31:24]} : temp_prev;

    aes_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        temp = temp_prev;
        if (phase == 3'd0) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && phase == 3'd4) begin
            temp = sub_out;
        end
    end

    assign w_new = w[idx - 6'(NK)] ^ temp;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = EXPAND;
            EXPAND:  if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            key_valid <= 1'b0;
            rcon      <= RCON_INIT;
            idx       <= 6'(NK);
            phase     <= 3'd0;
        end
`ifdef AES_KS_ZEROIZE_EN
        else if (key_clr) begin
            state     <= IDLE;
            done      <= 1'b0;
            key_valid <= 1'b0;
            rcon      <= RCON_INIT;
            idx       <= 6'(NK);
            phase     <= 3'd0;
        end
`endif
        else begin
            state <= state_nx;
            done  <= 1'b0;
            if (accept) begin
                key_valid <= 1'b0;
                rcon      <= RCON_INIT;
                idx       <= 6'(NK);
                phase     <= 3'd0;
            end else if (step) begin
                idx   <= idx + 6'd1;
                phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                if (phase == 3'd0) rcon <= xtime(rcon);
                if (last) begin
                    done      <= 1'b1;
                    key_valid <= 1'b1;
                end
            end
        end
    end

    // Store survives reset; only zeroize, key load and expansion write it
    always_ff @(posedge CLK) begin
`ifdef AES_KS_ZEROIZE_EN
        if (key_clr && !reset) begin
            for (int k = 0; k < NW; k++) w[k] <= '0;
        end else
`endif
        if (!reset && accept) begin
            for (int k = 0; k < NK; k++) w[k] <= key_in[KEY_BITS-1-32*k -: 32];
        end else if (!reset && step) begin
            w[idx] <= w_new;
        end
    end

    assign rd_base = {rd_round, 2'b00};

    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_key <= '0;
        end
`ifdef AES_KS_ZEROIZE_EN
        else if (key_clr) begin
            rd_key <= '0;
        end
`endif
        else if (rd_round > 4'(NR)) begin
            rd_key <= '0;
        end else begin
            rd_key <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
        end
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Parametrised, iterative AES key-schedule engine for AES-128/192/256. It generates one 32-bit schedule word per clock into an internal round-key store and returns any 128-bit round key through a registered read port. It replaces the single-round, externally sequenced `key_expansion` step: the cipher datapath issues one `start` and then indexes round keys by round number. Rcon sequencing and the round counter live inside the block.

## Interface
- `KEY_BITS`, 128, cipher key length: 128, 192 or 256. Any other value is an elaboration error. Derived: Nk = KEY_BITS/32 (4/6/8), Nr = Nk+6 (10/12/14), Nw = 4·(Nr+1) (44/52/60).
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request expansion of `key_in`; sampled only in IDLE.
- `key_in`  in  KEY_BITS  cipher key, word 0 in the MSBs (FIPS-197 byte order).
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse when the last word is written.
- `key_valid`  out  1  store holds a complete schedule for the last accepted key.
- `rd_round`  in  4  round index to read.
- `rd_key`  out  128  round key `rd_round`, registered.
- `key_clr`  in  1  zeroize request. Present only with `AES_KS_ZEROIZE_EN`.

## Operation
- States: IDLE, EXPAND.
- **IDLE:**
  - When `start`=1, latch `key_in` into w[0..Nk-1] and set i=Nk, rcon=0x01, `key_valid`=0, `busy`=1.
  - Then go to EXPAND.
- **EXPAND:** write one word per cycle, using temp = w[i-1]:
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon). xtime is the GF(2^8) doubling with 0x1B reduction.
  - Else if Nk=8 and i mod Nk = 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] ^ temp, and i increments.
  - When i = Nw-1 is written: return to IDLE, clear `busy`, pulse `done`, set `key_valid`=1.
- `start` while `busy`=1 is ignored. The running expansion is not disturbed.
- `start` while `key_valid`=1 and IDLE restarts expansion and drops `key_valid` at the accepting edge.
- **Read port:**
  - `rd_key` = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with r = `rd_round` sampled at the edge.
  - If `rd_round` > Nr, `rd_key` = 0.
  - Reads are allowed at any time. During EXPAND they return whatever the store holds, so the consumer must gate on `key_valid`.
- The i counter is wide enough for Nw-1 = 59, i.e. 6 bits. The i mod Nk comparison uses a separate 3-bit phase counter that wraps at Nk-1, so no divider is needed.

## Timing
- **Reset values:** `busy`=0, `done`=0, `key_valid`=0, `rd_key`=0, state IDLE, rcon=0x01. Store contents are not cleared by reset.
- **Latency:**
  - `start` is accepted at edge E0. The last word is written at edge E(Nw-Nk): E40, E46 or E52 for AES-128, -192, -256.
  - `done` and `key_valid` are high in the cycle after that edge.
  - `busy` is high from the cycle after E0 up to and including the cycle of edge E(Nw-Nk)'s evaluation.
- **Read latency:** `rd_key` reflects `rd_round` one cycle later.
- **Reset mid-EXPAND:** abort at that edge and go to IDLE; all outputs return to their reset values. A new `start` is accepted in the cycle after reset deasserts.
- **`start` and `reset` in the same cycle:** reset wins.

## Configuration
- `AES_KS_ZEROIZE_EN` defined:
  - The `key_clr` port exists.
  - `key_clr`=1 at an edge zeroes all Nw words, the key latch and `rd_key`. It also forces IDLE and clears `busy` and `key_valid`.
  - It has priority over `start` and is below `reset`.
- Undefined: the port is absent and there is no zeroize logic. The store is retained until it is overwritten.

## Structure
- **Package `aes_ks_pkg`:**
  - Functions for Nk, Nr and Nw from KEY_BITS.
  - `xtime` function.
  - State enum {IDLE, EXPAND}.
  - RCON_INIT = 8'h01.
- **Sub-module `aes_subword`:** four parallel S-box lookups on a 32-bit word, purely combinational. It is reusable by the cipher round logic.
- The store is a flat array of Nw × 32-bit registers, without a RAM macro, so that zeroize can be done in one cycle.

## Test plan
- **AES-128:** `key_in`=000102030405060708090a0b0c0d0e0f, pulse `start` → `done` exactly 41 cycles later. Round 0 reads back the key. Round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe. Round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- **AES-192:** key 000102…1617 → `done` after 47 cycles, round 12 = a4970a331a78dc09c418c271e3a41d5d.
- **AES-256:** key 000102…1e1f → `done` after 53 cycles, round 14 = 24fc79ccbf0979e9371ac23c6d68de36. `rd_round`=15 → 0.
- **Start during busy:** pulse `start` with a different key at cycle 10 of an expansion → ignored; the final keys match the first key.
- **Reset mid-operation:** assert `reset` at cycle 20 → `busy`/`key_valid`/`done` are 0 next cycle. A new `start` completes with correct keys.
- **Zeroize (macro on):** after a valid schedule, pulse `key_clr` → `key_valid`=0, and every `rd_round` 0..Nr reads 0.
